// File: rtl/scic_io_pkg.sv
// Shared constants for the SCIC I/O port: register map, ID word and STATUS bit layout.
package scic_io_pkg;

    typedef enum logic [1:0] {
        IO_ADDR_LED    = 2'd0,
        IO_ADDR_SW     = 2'd1,
        IO_ADDR_STATUS = 2'd2,
        IO_ADDR_ID     = 2'd3
    } io_reg_e;

    localparam logic [31:0] IO_ID_VALUE    = 32'h5C1C_0001;
    localparam int          STATUS_CHG_BIT = 0;

endpackage

// File: rtl/scic_io_port_if.sv
// SCIC core I/O bus: one-cycle request strobe, registered response strobe, level interrupt.
interface scic_io_port_if;

    logic        io_sel;
    logic        io_we;
    logic [1:0]  io_addr;
    logic [31:0] io_wdata;
    logic [31:0] io_rdata;
    logic        io_ready;
    logic        io_irq;

    modport master (
        output io_sel, io_we, io_addr, io_wdata,
        input  io_rdata, io_ready, io_irq
    );

    modport slave (
        input  io_sel, io_we, io_addr, io_wdata,
        output io_rdata, io_ready, io_irq
    );

endinterface

// File: rtl/scic_debounce.sv
// One switch bit: 2-flop synchroniser followed by a stability counter.
// The counter exists only when SCIC_IO_DEBOUNCE_EN is defined; otherwise stable is the synchroniser output.
module scic_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic stable,
    output logic toggle
);

    logic sync1;
    logic sync2;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

`ifdef SCIC_IO_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] count;
    logic          stable_q;

    // toggle fires on the edge where the count would reach DEBOUNCE_CYCLES
    always_comb begin
        toggle = (sync2 != stable_q) && (count == CW'(DEBOUNCE_CYCLES - 1));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count    <= '0;
            stable_q <= 1'b0;
        end else if (sync2 == stable_q) begin
            count <= '0;
        end else if (toggle) begin
            stable_q <= sync2;
            count    <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign stable = stable_q;
`else
    localparam int unused_cycles = DEBOUNCE_CYCLES;

    assign stable = sync2;
    assign toggle = sync1 ^ sync2;
`endif

endmodule

// File: rtl/scic_io_port.sv
// Memory-mapped LED/switch responder for the SCIC core with sticky change interrupt.
// Switch debouncing is enabled by defining SCIC_IO_DEBOUNCE_EN.
module scic_io_port
    import scic_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int NUM_SW          = 4,
    parameter int NUM_LED         = 4
) (
    input  logic               clock,
    input  logic               reset,
    scic_io_port_if.slave      io,
    input  logic [NUM_SW-1:0]  switches,
    output logic [NUM_LED-1:0] LEDs
);

    logic [NUM_SW-1:0]  sw_stable;
    logic [NUM_SW-1:0]  sw_toggle;
    logic [NUM_LED-1:0] led_q;
    logic               chg_q;
    logic               ready_q;
    logic [31:0]        rdata_q;
    logic [31:0]        rd_word;
    logic               wr_led;
    logic               wr_chg_clr;
    logic               unused_wdata;

    for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
        scic_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clock  (clock),
            .reset  (reset),
            .raw    (switches[i]),
            .stable (sw_stable[i]),
            .toggle (sw_toggle[i])
        );
    end

    always_comb begin
        wr_led     = io.io_sel && io.io_we && (io.io_addr == IO_ADDR_LED);
        wr_chg_clr = io.io_sel && io.io_we && (io.io_addr == IO_ADDR_STATUS)
                     && io.io_wdata[STATUS_CHG_BIT];
    end

    // Read mux sees pre-edge state, so a read returns values before any same-edge write
    always_comb begin
        rd_word = '0;
        case (io.io_addr)
            IO_ADDR_LED:    rd_word[NUM_LED-1:0]  = led_q;
            IO_ADDR_SW:     rd_word[NUM_SW-1:0]   = sw_stable;
            IO_ADDR_STATUS: rd_word[STATUS_CHG_BIT] = chg_q;
            IO_ADDR_ID:     rd_word = IO_ID_VALUE;
        endcase
    end

    // A new switch change outranks a same-edge write-1-to-clear
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            led_q   <= '0;
            chg_q   <= 1'b0;
            ready_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            ready_q <= io.io_sel;
            rdata_q <= (io.io_sel && !io.io_we) ? rd_word : '0;
            if (wr_led) begin
                led_q <= io.io_wdata[NUM_LED-1:0];
            end
            if (|sw_toggle) begin
                chg_q <= 1'b1;
            end else if (wr_chg_clr) begin
                chg_q <= 1'b0;
            end
        end
    end

    assign unused_wdata = ^io.io_wdata;

    assign io.io_ready = ready_q;
    assign io.io_rdata = rdata_q;
    assign io.io_irq   = chg_q;
    assign LEDs        = led_q;

endmodule

// File: tb/tb_scic_io_port.sv
// Directed bench for scic_io_port; bus responses are checked by a queue-based scoreboard monitor.
module tb_scic_io_port;
    import scic_io_pkg::*;

    localparam int DB = 4;
`ifdef SCIC_IO_DEBOUNCE_EN
    localparam int LAT = DB + 2;
`else
    localparam int LAT = 2;
`endif

    logic       clock;
    logic       reset;
    logic [3:0] switches;
    logic [3:0] LEDs;

    scic_io_port_if bus();

    scic_io_port #(
        .DEBOUNCE_CYCLES (DB),
        .NUM_SW          (4),
        .NUM_LED         (4)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .io       (bus),
        .switches (switches),
        .LEDs     (LEDs)
    );

    int          pass_cnt  = 0;
    int          check_cnt = 0;
    int          ready_run = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_cnt++;
        if (actual === expected) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // One bus request, sampled at the next rising edge; the expected response is queued now
    task automatic apply_stimulus(input logic we, input logic [1:0] addr, input logic [31:0] wdata,
                                  input logic [31:0] expected, input string name);
        bus.io_sel   = 1'b1;
        bus.io_we    = we;
        bus.io_addr  = addr;
        bus.io_wdata = wdata;
        exp_q.push_back(expected);
        name_q.push_back(name);
        @(posedge clock);
        #2;
    endtask

    task automatic idle(input int n);
        bus.io_sel   = 1'b0;
        bus.io_we    = 1'b0;
        bus.io_wdata = '0;
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    initial begin
        forever begin
            @(negedge clock);
            if (bus.io_ready) begin
                ready_run++;
                if (exp_q.size() == 0) begin
                    check_output("unexpected_ready", 32'(bus.io_ready), 32'd0);
                end else begin
                    check_output(name_q.pop_front(), bus.io_rdata, exp_q.pop_front());
                end
            end else begin
                ready_run = 0;
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset        = 1'b0;
        switches     = 4'b0000;
        bus.io_sel   = 1'b0;
        bus.io_we    = 1'b0;
        bus.io_addr  = 2'd0;
        bus.io_wdata = '0;

        @(negedge clock);
        check_output("rst_ready", 32'(bus.io_ready), 32'd0);
        check_output("rst_rdata", bus.io_rdata, 32'd0);
        check_output("rst_irq", 32'(bus.io_irq), 32'd0);
        check_output("rst_leds", 32'(LEDs), 32'd0);
        @(posedge clock);
        #2;
        reset = 1'b1;

        apply_stimulus(1'b0, IO_ADDR_LED, 32'd0, 32'd0, "rd_led_init");
        apply_stimulus(1'b0, IO_ADDR_SW, 32'd0, 32'd0, "rd_sw_init");
        apply_stimulus(1'b0, IO_ADDR_STATUS, 32'd0, 32'd0, "rd_status_init");
        apply_stimulus(1'b0, IO_ADDR_ID, 32'd0, 32'h5C1C_0001, "rd_id");
        idle(2);

        apply_stimulus(1'b1, IO_ADDR_LED, 32'hFFFF_FFF5, 32'd0, "wr_led_resp");
        @(negedge clock);
        check_output("leds_after_wr", 32'(LEDs), 32'h5);
        #1;
        apply_stimulus(1'b0, IO_ADDR_LED, 32'd0, 32'h0000_0005, "rd_after_wr");
        @(negedge clock);
        #1;
        check_output("ready_b2b", 32'(ready_run), 32'd2);
        idle(1);

`ifdef SCIC_IO_DEBOUNCE_EN
        switches = 4'b0001;
        idle(3);
        switches = 4'b0000;
        idle(8);
        check_output("glitch_irq", 32'(bus.io_irq), 32'd0);
        apply_stimulus(1'b0, IO_ADDR_SW, 32'd0, 32'd0, "glitch_sw");
        apply_stimulus(1'b0, IO_ADDR_STATUS, 32'd0, 32'd0, "glitch_status");
        idle(1);
`endif

        // Pin change is first sampled by the next edge; SW and CHG update LAT edges in
        switches = 4'b0011;
        idle(LAT - 1);
        @(negedge clock);
        check_output("irq_before_lat", 32'(bus.io_irq), 32'd0);
        #1;
        apply_stimulus(1'b0, IO_ADDR_SW, 32'd0, 32'd0, "sw_before_lat");
        @(negedge clock);
        check_output("irq_at_lat", 32'(bus.io_irq), 32'd1);
        #1;
        apply_stimulus(1'b0, IO_ADDR_SW, 32'd0, 32'd3, "sw_after_lat");
        apply_stimulus(1'b0, IO_ADDR_STATUS, 32'd0, 32'd1, "status_chg");
        apply_stimulus(1'b1, IO_ADDR_STATUS, 32'd1, 32'd0, "w1c_resp");
        @(negedge clock);
        check_output("irq_cleared", 32'(bus.io_irq), 32'd0);
        #1;
        idle(1);

        switches = 4'b0001;
        idle(LAT - 1);
        apply_stimulus(1'b1, IO_ADDR_STATUS, 32'd1, 32'd0, "collide_resp");
        @(negedge clock);
        check_output("collide_irq", 32'(bus.io_irq), 32'd1);
        #1;
        apply_stimulus(1'b0, IO_ADDR_STATUS, 32'd0, 32'd1, "collide_status");
        apply_stimulus(1'b0, IO_ADDR_SW, 32'd0, 32'd1, "collide_sw");
        idle(1);

        apply_stimulus(1'b1, IO_ADDR_LED, 32'h0000_000F, 32'd0, "wr_led_f");
        @(negedge clock);
        check_output("leds_f", 32'(LEDs), 32'hF);
        #1;
        apply_stimulus(1'b0, IO_ADDR_LED, 32'd0, 32'hF, "rd_dropped");
        bus.io_sel = 1'b0;
        exp_q.delete();
        name_q.delete();
        reset = 1'b0;
        #1;
        check_output("mid_rst_ready", 32'(bus.io_ready), 32'd0);
        check_output("mid_rst_rdata", bus.io_rdata, 32'd0);
        check_output("mid_rst_leds", 32'(LEDs), 32'd0);
        check_output("mid_rst_irq", 32'(bus.io_irq), 32'd0);
        idle(2);
        reset = 1'b1;
        apply_stimulus(1'b0, IO_ADDR_STATUS, 32'd0, 32'd0, "post_rst_status");
        apply_stimulus(1'b0, IO_ADDR_LED, 32'd0, 32'd0, "post_rst_led");
        idle(3);

        check_output("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/scic_io_port.md
# scic_io_port

Memory-mapped I/O responder for the SCIC processor. Owns the board LEDs and switches: the CPU writes an LED output register and reads a debounced, synchronised copy of the switches. A sticky change flag raises an interrupt request. It sits between the SCIC core's I/O bus and the top-level `LEDs`/`switches` pins.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable samples required before a switch change is accepted (≥1).
- `NUM_SW`, default 4: number of switches.
- `NUM_LED`, default 4: number of LEDs.
- `clock`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-low. Asserted (0) clears all state immediately.
- `io_sel`  in  1: request strobe. One request per cycle in which it is high.
- `io_we`  in  1: 1 = write, 0 = read. Qualified by `io_sel`.
- `io_addr`  in  2: register select.
- `io_wdata`  in  32: write data.
- `io_rdata`  out  32: read data. Valid while `io_ready`=1; 0 otherwise.
- `io_ready`  out  1: response strobe, one cycle after each request.
- `io_irq`  out  1: equals the STATUS.CHG flag.
- `switches`  in  NUM_SW: raw asynchronous switch pins.
- `LEDs`  out  NUM_LED: driven from the LED register.

## Operation
- Register map (word addresses):
  - 0 LED: RW, bits [NUM_LED-1:0]; upper bits read 0.
  - 1 SW: RO, debounced switch value, zero-extended; writes ignored.
  - 2 STATUS: bit0 CHG (sticky), write-1-to-clear; other bits read 0.
  - 3 ID: RO constant 32'h5C1C_0001.
- Each switch input passes through a 2-flop synchroniser, then a debouncer.
- Debouncer, per bit:
  - holds a `stable` value and a counter of width $clog2(DEBOUNCE_CYCLES+1).
  - When the synchronised value ≠ `stable`, the counter increments. When it reaches DEBOUNCE_CYCLES, `stable` takes the new value and the counter clears.
  - Any cycle with synchronised value = `stable` clears the counter, so a glitch restarts the count.
- CHG is set on any edge where any `stable` bit changes.
- Set/clear collision: if a W1C write to CHG and a new change happen on the same edge, set wins (CHG=1).
- Reads have no side effects.
- Writes to SW or ID are acknowledged with `io_ready` and have no effect.

## Timing
- Reset values:
  - `LEDs`=0, `io_ready`=0, `io_rdata`=0, `io_irq`=0, CHG=0.
  - All `stable`=0, all counters=0, synchronisers=0.
- Request sampled at edge k:
  - `io_ready`=1 during cycle k+1.
  - Read: `io_rdata` reflects register state before edge k's writes.
  - Write: takes effect at edge k; `LEDs` shows the new value from cycle k+1.
- Back-to-back requests every cycle are allowed. `io_ready` stays high continuously, one response per request, in order.
- Read-after-write on consecutive cycles returns the written value.
- Switch latency: a raw pin change held steady appears in SW (and sets CHG) DEBOUNCE_CYCLES+2 edges after it is first sampled.
- Reset asserted mid-request: the response is dropped, `io_ready` goes 0 immediately, and no partial write survives.

## Configuration
- `SCIC_IO_DEBOUNCE_EN` defined: debouncer as above.
- Undefined: no debouncer or counters. `stable` = synchroniser output; latency becomes 2 edges; CHG sets on any change of the synchronised value. `DEBOUNCE_CYCLES` is ignored.

## Structure
- Package `scic_io_pkg`: register address constants (`IO_ADDR_LED`, `IO_ADDR_SW`, `IO_ADDR_STATUS`, `IO_ADDR_ID`), `IO_ID_VALUE`, and `STATUS_CHG_BIT`.
- Sub-module `scic_debounce`: one bit, containing the synchroniser and the debounce counter, parameterised by DEBOUNCE_CYCLES and with the macro applied inside it. `scic_io_port` instantiates it NUM_SW times via generate.

## Test plan
Bench uses DEBOUNCE_CYCLES=4.
- Reset release: read all four addresses → LED=0, SW=0, STATUS=0, ID=32'h5C1C_0001; `LEDs`=4'b0000.
- Write LED=32'hFFFF_FFF5, then read LED on the next cycle → `LEDs`=4'b0101 from the cycle after the write; read returns 32'h0000_0005; `io_ready` high for two consecutive cycles.
- Drive `switches`=4'b0011 steady → SW reads 3 and `io_irq`=1 exactly 6 edges after first sampling. Write STATUS=1 → `io_irq`=0 next cycle.
- Glitch: `switches` bit0 high for 3 cycles, then back low → SW unchanged and CHG stays 0.
- Collision: time a STATUS W1C write to the edge where SW changes → CHG remains 1.
- Assert `reset`=0 while a read is pending and `LEDs`=4'b1111 → `io_ready`, `LEDs` and CHG are 0 immediately. With the macro undefined, a switch change reaches SW after 2 edges.
